// File: rtl/code_verifier.sv
// Code verifier: snapshots eight BCD digits on a check event and compares them
// against a secret code in fixed time, driving unlock / error / lockout status.
module code_verifier #(
  parameter logic [31:0] CODE           = 32'h00000000,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCKOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       check_req,
  input  logic       relock,
  input  logic [2:0] state,
  input  logic [2:0] state_need,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  input  logic [3:0] digit5,
  input  logic [3:0] digit6,
  input  logic [3:0] digit7,
  input  logic [3:0] digit8,
  output logic       busy,
  output logic       unlocked,
  output logic       error,
  output logic       locked_out,
  output logic [3:0] attempts_left
);

  localparam int              LCW       = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [3:0]      ATT_INIT  = 4'(MAX_ATTEMPTS);
  localparam logic [LCW-1:0]  LOCK_LOAD = LCW'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]      IDX_LAST  = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    UNLOCKED,
    LOCKOUT
  } fsm_t;

  fsm_t           fsm_reg, fsm_next;
  logic [3:0]     idx_reg, idx_next;
  logic           mismatch_reg, mismatch_next;
  logic [LCW-1:0] lock_cnt_reg, lock_cnt_next;
  logic [3:0]     attempts_reg, attempts_next;
  logic           error_reg, error_next;
  logic           check_d_reg;
  logic [3:0]     snap_reg [8];

  logic [3:0]     digit_in [8];
  logic [3:0]     code_nib [8];
  logic           check_event;
  logic           accept;
  logic           last_attempt;
  logic [3:0]     cur_digit;
  logic [3:0]     cur_code;
  logic           cur_bad;

  assign digit_in[0] = digit1;
  assign digit_in[1] = digit2;
  assign digit_in[2] = digit3;
  assign digit_in[3] = digit4;
  assign digit_in[4] = digit5;
  assign digit_in[5] = digit6;
  assign digit_in[6] = digit7;
  assign digit_in[7] = digit8;

  // digit1 pairs with the most significant nibble of CODE
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_code_nib
      assign code_nib[gi] = CODE[31-4*gi -: 4];
    end
  endgenerate

  assign check_event  = check_req & ~check_d_reg;
  assign accept       = (fsm_reg == IDLE) && check_event && (state == state_need) && !relock;
  assign last_attempt = (attempts_reg <= 4'd1);

  // Non-BCD digits are rejected even when the code nibble holds the same value
  assign cur_digit = snap_reg[idx_reg[2:0]];
  assign cur_code  = code_nib[idx_reg[2:0]];
  assign cur_bad   = (cur_digit != cur_code) || (cur_digit > 4'd9);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg      <= IDLE;
      idx_reg      <= '0;
      mismatch_reg <= 1'b0;
      lock_cnt_reg <= '0;
      attempts_reg <= ATT_INIT;
      error_reg    <= 1'b0;
      check_d_reg  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        snap_reg[i] <= '0;
      end
    end else begin
      fsm_reg      <= fsm_next;
      idx_reg      <= idx_next;
      mismatch_reg <= mismatch_next;
      lock_cnt_reg <= lock_cnt_next;
      attempts_reg <= attempts_next;
      error_reg    <= error_next;
      check_d_reg  <= check_req;
      if (accept) begin
        for (int i = 0; i < 8; i++) begin
          snap_reg[i] <= digit_in[i];
        end
      end
    end
  end

  // Next-state logic
  always_comb begin
    fsm_next = fsm_reg;
    unique case (fsm_reg)
      IDLE: begin
        if (accept) begin
          fsm_next = COMPARE;
        end
      end
      COMPARE: begin
        if (idx_reg == IDX_LAST) begin
          if (!mismatch_reg) begin
            fsm_next = UNLOCKED;
          end else if (last_attempt) begin
            fsm_next = LOCKOUT;
          end else begin
            fsm_next = IDLE;
          end
        end
      end
      UNLOCKED: begin
        if (relock) begin
          fsm_next = IDLE;
        end
      end
      LOCKOUT: begin
        if (lock_cnt_reg == '0) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // Datapath and output logic; the compare always walks all eight digits
  always_comb begin
    idx_next      = idx_reg;
    mismatch_next = mismatch_reg;
    lock_cnt_next = lock_cnt_reg;
    attempts_next = attempts_reg;
    error_next    = 1'b0;
    unique case (fsm_reg)
      IDLE: begin
        if (accept) begin
          idx_next      = '0;
          mismatch_next = 1'b0;
        end
      end
      COMPARE: begin
        if (idx_reg != IDX_LAST) begin
          mismatch_next = mismatch_reg | cur_bad;
          idx_next      = idx_reg + 4'd1;
        end else if (mismatch_reg) begin
          error_next = 1'b1;
          if (last_attempt) begin
            attempts_next = 4'd0;
            lock_cnt_next = LOCK_LOAD;
          end else begin
            attempts_next = attempts_reg - 4'd1;
          end
        end else begin
          attempts_next = ATT_INIT;
        end
      end
      UNLOCKED: begin
      end
      LOCKOUT: begin
        if (lock_cnt_reg == '0) begin
          attempts_next = ATT_INIT;
        end else begin
          lock_cnt_next = lock_cnt_reg - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign busy          = (fsm_reg == COMPARE);
  assign unlocked      = (fsm_reg == UNLOCKED);
  assign locked_out    = (fsm_reg == LOCKOUT);
  assign error         = error_reg;
  assign attempts_left = attempts_reg;

endmodule

// File: tb/tb_code_verifier.sv
// Bench for code_verifier: per-cycle comparison against a transaction-level
// model plus directed scenarios with hand-computed expectations.
module tb_code_verifier;

  localparam logic [31:0] CODE   = 32'h12345678;
  localparam logic [31:0] CODE_A = 32'h1234A678;
  localparam int          MAXA   = 3;
  localparam int          LOCK   = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       check_req;
  logic       relock;
  logic [2:0] state;
  logic [2:0] state_need;
  logic [3:0] digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8;
  logic       busy, unlocked, error, locked_out;
  logic [3:0] attempts_left;
  logic       busy_a, unlocked_a, error_a, locked_out_a;
  logic [3:0] attempts_left_a;

  int n_assert = 0;
  int n_fail   = 0;
  int acc_busy, acc_err, acc_lock, acc_busy_a, acc_err_a;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  code_verifier #(.CODE(CODE), .MAX_ATTEMPTS(MAXA), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .rst(rst), .check_req(check_req), .relock(relock),
    .state(state), .state_need(state_need),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .digit5(digit5), .digit6(digit6), .digit7(digit7), .digit8(digit8),
    .busy(busy), .unlocked(unlocked), .error(error), .locked_out(locked_out),
    .attempts_left(attempts_left)
  );

  // Second instance whose code contains a non-BCD nibble
  code_verifier #(.CODE(CODE_A), .MAX_ATTEMPTS(MAXA), .LOCKOUT_CYCLES(LOCK)) dut_a (
    .clk(clk), .rst(rst), .check_req(check_req), .relock(relock),
    .state(state), .state_need(state_need),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .digit5(digit5), .digit6(digit6), .digit7(digit7), .digit8(digit8),
    .busy(busy_a), .unlocked(unlocked_a), .error(error_a), .locked_out(locked_out_a),
    .attempts_left(attempts_left_a)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a check is a whole-word comparison whose result
  // appears a fixed number of cycles after acceptance.
  localparam int M_IDLE = 0, M_BUSY = 1, M_UNL = 2, M_LOCK = 3;
  int   m_mode = M_IDLE;
  int   m_att  = MAXA;
  int   m_left = 0;
  bit   m_err  = 0;
  bit   m_pass = 0;
  bit   m_prev = 0;
  bit   m_ev;
  int   n_txn  = 0;

  function automatic bit code_ok(input logic [31:0] d);
    logic [31:0] t;
    if (d != CODE) return 1'b0;
    for (int k = 0; k < 8; k++) begin
      t = (d >> (4 * k)) & 32'hF;
      if (t > 32'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    m_err = 0;
    if (rst) begin
      m_mode = M_IDLE;
      m_att  = MAXA;
      m_prev = 0;
    end else begin
      m_ev = check_req && !m_prev;
      case (m_mode)
        M_IDLE: if (m_ev && state == state_need && !relock) begin
          m_pass = code_ok({digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8});
          m_left = 9;
          m_mode = M_BUSY;
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) begin
            n_txn++;
            if (m_pass) begin
              m_mode = M_UNL;
              m_att  = MAXA;
            end else begin
              m_err = 1;
              m_att--;
              if (m_att == 0) begin
                m_mode = M_LOCK;
                m_left = LOCK;
              end else begin
                m_mode = M_IDLE;
              end
            end
            $display("check %0d: match=%0d attempts_left=%0d lockout=%0d", n_txn, m_pass, m_att, m_mode == M_LOCK);
          end
        end
        M_UNL: if (relock) m_mode = M_IDLE;
        M_LOCK: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_IDLE;
            m_att  = MAXA;
          end
        end
        default: m_mode = M_IDLE;
      endcase
      m_prev = check_req;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_mode == M_BUSY));
      chk("unlocked", int'(unlocked), int'(m_mode == M_UNL));
      chk("locked_out", int'(locked_out), int'(m_mode == M_LOCK));
      chk("error", int'(error), int'(m_err));
      chk("attempts_left", int'(attempts_left), m_att);
    end
  end

  task automatic set_digits(input logic [31:0] v);
    {digit1, digit2, digit3, digit4, digit5, digit6, digit7, digit8} = v;
  endtask

  task automatic clr();
    acc_busy = 0; acc_err = 0; acc_lock = 0; acc_busy_a = 0; acc_err_a = 0;
  endtask

  task automatic step();
    @(negedge clk);
    acc_busy   += int'(busy);
    acc_err    += int'(error);
    acc_lock   += int'(locked_out);
    acc_busy_a += int'(busy_a);
    acc_err_a  += int'(error_a);
  endtask

  // One-cycle check pulse followed by a fixed 12-cycle observation window
  task automatic run_check();
    step();
    check_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      check_req = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; check_req = 1'b0; relock = 1'b0;
    state = 3'd3; state_need = 3'd3;
    set_digits(32'h12345678);
    @(negedge clk); @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset attempts_left", int'(attempts_left), 3);
    chk("reset busy", int'(busy), 0);
    chk("reset unlocked", int'(unlocked), 0);

    // Non-BCD digit equal to the code nibble still mismatches
    set_digits(32'h1234A678);
    clr(); run_check();
    chk("hexA dut_a busy cycles", acc_busy_a, 9);
    chk("hexA dut_a error pulses", acc_err_a, 1);
    chk("hexA dut_a unlocked", int'(unlocked_a), 0);
    chk("hexA dut_a attempts", int'(attempts_left_a), 2);
    chk("hexA dut_a locked_out", int'(locked_out_a), 0);
    chk("hexA attempts", int'(attempts_left), 2);

    // Correct code
    set_digits(32'h12345678);
    clr(); run_check();
    chk("match busy cycles", acc_busy, 9);
    chk("match error pulses", acc_err, 0);
    chk("match unlocked", int'(unlocked), 1);
    chk("match attempts", int'(attempts_left), 3);

    // Relock and a check event on the same edge: relock wins
    step();
    relock = 1'b1; check_req = 1'b1;
    clr(); step();
    relock = 1'b0; check_req = 1'b0;
    chk("relock unlocked", int'(unlocked), 0);
    for (int i = 0; i < 3; i++) step();
    chk("relock no check", acc_busy, 0);

    // Wrong last digit
    set_digits(32'h12345679);
    clr(); run_check();
    chk("wrong busy cycles", acc_busy, 9);
    chk("wrong error pulses", acc_err, 1);
    chk("wrong attempts", int'(attempts_left), 2);

    // Not in the accepting state
    set_digits(32'h12345678);
    state = 3'd5;
    clr(); run_check();
    chk("state gate busy", acc_busy, 0);
    chk("state gate attempts", int'(attempts_left), 2);
    state = 3'd3;

    // Reset at edge 4 of a compare
    clr(); step();
    check_req = 1'b1; step();
    check_req = 1'b0; step(); step(); step();
    rst = 1'b1; step();
    chk("midreset busy", int'(busy), 0);
    chk("midreset attempts", int'(attempts_left), 3);
    rst = 1'b0;
    clr(); run_check();
    chk("post-reset busy cycles", acc_busy, 9);
    chk("post-reset unlocked", int'(unlocked), 1);
    step(); relock = 1'b1; step(); relock = 1'b0;

    // Held check_req, digits corrected mid-compare: snapshot keeps the wrong code
    set_digits(32'h12345670);
    clr(); step();
    check_req = 1'b1; step();
    set_digits(32'h12345678);
    for (int i = 0; i < 30; i++) step();
    check_req = 1'b0; step();
    chk("held busy cycles", acc_busy, 9);
    chk("held error pulses", acc_err, 1);
    chk("held unlocked", int'(unlocked), 0);
    chk("held attempts", int'(attempts_left), 2);

    // Two more failures reach lockout; a check during lockout is ignored
    set_digits(32'h87654321);
    run_check();
    chk("second fail attempts", int'(attempts_left), 1);
    clr(); run_check();
    chk("lockout attempts", int'(attempts_left), 0);
    run_check();
    for (int i = 0; i < 5; i++) step();
    chk("lockout busy cycles", acc_busy, 9);
    chk("lockout error pulses", acc_err, 1);
    chk("lockout length", acc_lock, 16);
    chk("after lockout attempts", int'(attempts_left), 3);
    set_digits(32'h12345678);
    clr(); run_check();
    chk("after lockout unlocked", int'(unlocked), 1);
    chk("after lockout busy cycles", acc_busy, 9);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/code_verifier.md
Name: code_verifier

Overview:
- Reader side of the digit-entry path: samples the eight 4-bit BCD digit registers (digit1..digit8) written by the digit-increment logic.
- On a check request, compares the sampled digits against a parameterised secret code, one digit per cycle, taking the same number of cycles whether or not the digits match.
- Drives the unlock/error/lockout indications consumed by the lock top-level FSM and display.

Parameters:
- CODE, 32'h00000000, secret code as 8 BCD nibbles; CODE[31:28] pairs with digit1 and CODE[3:0] pairs with digit8.
- MAX_ATTEMPTS, 3, consecutive failed checks allowed before lockout; range 1..15.
- LOCKOUT_CYCLES, 1000, clock cycles spent in lockout; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- check_req  input  1  check button level, already synchronised; the block edge-detects it internally.
- relock  input  1  level; returns the block from UNLOCKED to IDLE.
- state  input  3  top-level lock state.
- state_need  input  3  state in which checks are accepted.
- digit1..digit8  input  4 each  entered digits.
- busy  output  1  high while a capture or compare is in progress.
- unlocked  output  1  level; set by a successful check.
- error  output  1  one-cycle pulse on a failed check.
- locked_out  output  1  high during lockout.
- attempts_left  output  4  failed checks remaining before lockout.

Behaviour:
- Reset values:
  - busy=0, unlocked=0, error=0, locked_out=0, attempts_left=MAX_ATTEMPTS.
  - FSM=IDLE; compare index=0; mismatch flag=0; lockout counter=0; check_req history register=0.
- Edge detection: a check event is a cycle where check_req=1 and its registered previous value=0. A held-high check_req produces exactly one event.
- States: IDLE, COMPARE, UNLOCKED, LOCKOUT.
- IDLE:
  - Accepts an event only if state==state_need and relock=0.
  - On the accepting edge (edge 0): snapshot all eight digits, clear the mismatch flag, set index=0, set busy=1, go to COMPARE.
  - Events not accepted are dropped, not queued.
- COMPARE:
  - Edges 1..8 each compare one snapshot digit (index 0..7, digit1 first) against its CODE nibble and OR any inequality into the mismatch flag.
  - No early exit.
  - Any digit value above 9 counts as a mismatch, even if CODE holds the same nibble.
  - Live digit inputs are ignored after the snapshot.
- Result on edge 9; busy falls on edge 9 in every case.
  - Match: unlocked=1, attempts_left=MAX_ATTEMPTS, go to UNLOCKED.
  - Mismatch with attempts_left>1: error=1 for exactly one cycle, attempts_left decrements, go to IDLE.
  - Mismatch with attempts_left==1: error=1 for one cycle, attempts_left=0, locked_out=1, lockout counter loaded with LOCKOUT_CYCLES-1, go to LOCKOUT.
  - Total check latency is fixed at 9 edges after edge 0.
- Check events during COMPARE are ignored.
- UNLOCKED:
  - Check events are ignored.
  - relock=1 clears unlocked and goes to IDLE on the same edge.
  - When relock and a check event coincide, relock wins and the event is dropped.
- LOCKOUT:
  - The counter decrements each cycle; all check events are ignored.
  - On the edge where the counter is 0: locked_out=0, attempts_left=MAX_ATTEMPTS, go to IDLE.
  - locked_out is therefore high for exactly LOCKOUT_CYCLES cycles.
- relock has no effect outside UNLOCKED.
- state/state_need are examined only when an event is accepted in IDLE; a later change does not abort a check in progress.
- Reset asserted in any state, including mid-COMPARE or mid-LOCKOUT, returns all outputs and registers to their reset values on that edge and discards the snapshot.

Test Plan:
- CODE=32'h12345678, digits 1..8, state==state_need, pulse check_req -> busy high for edges 0..8; on edge 9 unlocked=1, error=0, attempts_left=3.
- Same CODE, digit8=9, check -> error high for exactly one cycle at edge 9, unlocked=0, attempts_left=2; latency equals the match case.
- MAX_ATTEMPTS=3, LOCKOUT_CYCLES=16, three wrong checks -> locked_out high for exactly 16 cycles with attempts_left=0; a check pulse during lockout gives no busy and no error; afterwards attempts_left=3 and a correct check unlocks.
- check_req held high for 30 cycles -> exactly one check; digits changed during COMPARE do not affect the result; digit value 4'hA with CODE nibble 4'hA -> mismatch.
- state!=state_need with a check pulse -> busy stays 0 and no outputs change; in UNLOCKED, relock and a check event on the same edge -> unlocked=0, FSM=IDLE, no check started.
- rst asserted at edge 4 of a compare -> next cycle busy=0, attempts_left=3, FSM=IDLE; a fresh check then completes normally.
